cint_sequencer: RTL and testbench
=================================

CINT_SEQUENCER -- requirements
Module: cint_sequencer

Interface
REQ-001 SHALL have parameter CALL_VECTOR, default 16'h0008, PC target for a CINT0 CALL.
REQ-002 SHALL have parameter RST_VECTOR, default 16'h0000, PC target for a CINT0 RST.
REQ-003 SHALL have parameter STACK_PAGE, default 8'h01, high byte of every stack address.
REQ-004 SHALL have port CLK  in  1  single system clock; all state changes on the rising edge.
REQ-005 SHALL have port notRESET  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable_cint  in  1  high while the decoder has a CINT0 instruction.
REQ-007 SHALL have port P2_Reset_CINT  in  1  CINT0 request strobe.
REQ-008 SHALL have port P2_Set_CINT0_RST  in  1  request is the RST variant.
REQ-009 SHALL have port P2_Set_CINT0_CALL  in  1  request is the CALL variant.
REQ-010 SHALL have port pc_in  in  16  current PC, the return address.
REQ-011 SHALL have port mem_ready  in  1  memory accepted the current write.
REQ-012 SHALL have port mem_we  out  1  stack write request.
REQ-013 SHALL have port mem_addr  out  16  write address {STACK_PAGE, sp}.
REQ-014 SHALL have port mem_wdata  out  8  byte to write.
REQ-015 SHALL have port pc_load / pc_value  out  1 / 16  one-cycle PC load strobe and target.
REQ-016 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-017 SHALL have port sp  out  8  current stack pointer.
REQ-018 SHALL have port stack_ovf  out  1  sticky stack wrap flag.

Function
REQ-019 SHALL implement the states IDLE, PUSH_HI, PUSH_LO, LOAD and no others.
REQ-020 SHALL accept a request in IDLE only, at an edge where enable_cint=1 and P2_Reset_CINT=1, and SHALL latch pc_in at that edge.
REQ-021 SHALL, at acceptance: go to LOAD with target RST_VECTOR when P2_Set_CINT0_RST=1; otherwise go to PUSH_HI with target CALL_VECTOR when P2_Set_CINT0_CALL=1; otherwise stay in IDLE.
REQ-022 SHALL give RST priority when both variant inputs are high.
REQ-023 SHALL ignore all request inputs while busy=1; no queuing.
REQ-024 SHALL, in PUSH_HI, drive mem_we=1, mem_addr={STACK_PAGE,sp} and mem_wdata=latched PC[15:8].
REQ-025 SHALL hold the PUSH_HI outputs until an edge with mem_ready=1, then decrement sp and go to PUSH_LO.
REQ-026 SHALL behave the same way in PUSH_LO with PC[7:0], then go to LOAD.
REQ-027 SHALL, in LOAD, drive pc_load=1 and pc_value=target for exactly one cycle, then return to IDLE.
REQ-028 SHALL, for RST, also set sp to 8'hFF at the LOAD edge.
REQ-029 SHALL make CALL latency exactly 3 cycles plus mem_ready wait cycles, and RST latency 1 cycle.
REQ-030 SHALL wrap sp from 8'h00 to 8'hFF on decrement, and that wrap SHALL set stack_ovf; only reset clears stack_ovf.
REQ-031 SHALL drive mem_we, pc_load, mem_addr and mem_wdata to 0 outside their states.

Reset
REQ-032 SHALL, while notRESET=0, immediately force state IDLE, sp=8'hFF, stack_ovf=0, busy=0, all strobes 0 and pc_value=0.
REQ-033 SHALL, on reset mid-sequence, abandon the sequence with no further writes or loads.

Configuration
REQ-034 SHALL, with CINT_IRQ_MASK_EN defined, add output irq_enable (reset 1), clear it at CALL acceptance, and set it at RST acceptance.
REQ-035 SHALL, without CINT_IRQ_MASK_EN, have no irq_enable port or register, with all other behaviour identical.

Verification
REQ-036 SHALL test CALL: pc_in=16'h1234, mem_ready=1 -> writes 8'h12 at 16'h01FF, then 8'h34 at 16'h01FE; pc_load with 16'h0008 on cycle 3; sp=8'hFD.
REQ-037 SHALL test RST after two CALLs -> no write; pc_value=16'h0000 one cycle later; sp=8'hFF.
REQ-038 SHALL test mem_ready low for 4 cycles in PUSH_HI -> outputs held stable and latency of 7 cycles.
REQ-039 SHALL test 128 CALLs from reset -> the 128th CALL's PUSH_LO writes 16'h0100 and leaves sp=8'hFF with stack_ovf=1 (the 256th decrement wraps).
REQ-040 SHALL test both variants high and a request while busy -> RST taken and the second request dropped.
REQ-041 SHALL test notRESET low during PUSH_LO -> immediate IDLE, no pc_load, sp=8'hFF.

Source files
------------

// File: rtl/cint_sequencer.sv
// CINT0 sequencer: pushes the return PC onto the stack page for a CALL, or resets the stack for an RST, then loads the PC target.
// Optional interrupt-mask output irq_enable is built only when CINT_IRQ_MASK_EN is defined.
module cint_sequencer #(
    parameter logic [15:0] CALL_VECTOR = 16'h0008,
    parameter logic [15:0] RST_VECTOR  = 16'h0000,
    parameter logic [7:0]  STACK_PAGE  = 8'h01
) (
    input  logic        CLK,
    input  logic        notRESET,
    input  logic        enable_cint,
    input  logic        P2_Reset_CINT,
    input  logic        P2_Set_CINT0_RST,
    input  logic        P2_Set_CINT0_CALL,
    input  logic [15:0] pc_in,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        busy,
    output logic [7:0]  sp,
`ifdef CINT_IRQ_MASK_EN
    output logic        irq_enable,
`endif
    output logic        stack_ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_HI = 2'd1,
        PUSH_LO = 2'd2,
        LOAD    = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] pc_latch;
    logic [15:0] target;
    logic        is_rst;
    logic        dec_sp;
    logic        accept;
    logic        take_rst;
    logic        take_call;

    // RST wins over CALL when both variant inputs are high.
    assign accept    = (state == IDLE) && enable_cint && P2_Reset_CINT;
    assign take_rst  = accept && P2_Set_CINT0_RST;
    assign take_call = accept && !P2_Set_CINT0_RST && P2_Set_CINT0_CALL;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        pc_load    = 1'b0;
        pc_value   = 16'h0000;
        dec_sp     = 1'b0;
        case (state)
            IDLE: begin
                if (take_rst) begin
                    next_state = LOAD;
                end else if (take_call) begin
                    next_state = PUSH_HI;
                end
            end
            PUSH_HI: begin
                mem_we    = 1'b1;
                mem_addr  = {STACK_PAGE, sp};
                mem_wdata = pc_latch[15:8];
                if (mem_ready) begin
                    dec_sp     = 1'b1;
                    next_state = PUSH_LO;
                end
            end
            PUSH_LO: begin
                mem_we    = 1'b1;
                mem_addr  = {STACK_PAGE, sp};
                mem_wdata = pc_latch[7:0];
                if (mem_ready) begin
                    dec_sp     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                pc_load    = 1'b1;
                pc_value   = target;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: return address, target, stack pointer and the sticky wrap flag.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            pc_latch   <= 16'h0000;
            target     <= 16'h0000;
            is_rst     <= 1'b0;
            sp         <= 8'hFF;
            stack_ovf  <= 1'b0;
`ifdef CINT_IRQ_MASK_EN
            irq_enable <= 1'b1;
`endif
        end else begin
            if (accept) begin
                pc_latch <= pc_in;
            end
            if (take_rst) begin
                target     <= RST_VECTOR;
                is_rst     <= 1'b1;
`ifdef CINT_IRQ_MASK_EN
                irq_enable <= 1'b1;
`endif
            end else if (take_call) begin
                target     <= CALL_VECTOR;
                is_rst     <= 1'b0;
`ifdef CINT_IRQ_MASK_EN
                irq_enable <= 1'b0;
`endif
            end
            if (dec_sp) begin
                sp <= sp - 8'd1;
                if (sp == 8'h00) begin
                    stack_ovf <= 1'b1;
                end
            end else if ((state == LOAD) && is_rst) begin
                sp <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_cint_sequencer.sv
// Self-checking bench for cint_sequencer: vector table plus hand-written reset and stack-wrap sequences,
// with a scoreboard of expected stack writes and PC loads checked by a negedge monitor.
module tb_cint_sequencer;

    logic        CLK;
    logic        notRESET;
    logic        enable_cint;
    logic        P2_Reset_CINT;
    logic        P2_Set_CINT0_RST;
    logic        P2_Set_CINT0_CALL;
    logic [15:0] pc_in;
    logic        mem_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        busy;
    logic [7:0]  sp;
    logic        stack_ovf;

    cint_sequencer dut (
        .CLK               (CLK),
        .notRESET          (notRESET),
        .enable_cint       (enable_cint),
        .P2_Reset_CINT     (P2_Reset_CINT),
        .P2_Set_CINT0_RST  (P2_Set_CINT0_RST),
        .P2_Set_CINT0_CALL (P2_Set_CINT0_CALL),
        .pc_in             (pc_in),
        .mem_ready         (mem_ready),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .pc_load           (pc_load),
        .pc_value          (pc_value),
        .busy              (busy),
        .sp                (sp),
        .stack_ovf         (stack_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        strobe;
        logic        rst;
        logic        call;
        logic [15:0] pc;
        int          wait_cycles;
        logic        busy_req;
        int          exp_lat;
        logic [7:0]  exp_sp;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    localparam int NV = 10;
    vec_t        vecs[NV];
    wr_t         wq[$];
    logic [15:0] lq[$];
    logic [7:0]  model_sp;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted write and every PC load must match the front of its queue.
    always @(negedge CLK) begin
        if (notRESET) begin
            if (mem_we && mem_ready) begin
                if (wq.size() == 0) begin
                    checkOutput("unexp_write", 16'(mem_we), 16'h0000);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    checkOutput("wr_addr", mem_addr, e.addr);
                    checkOutput("wr_data", 16'(mem_wdata), 16'(e.data));
                end
            end
            if (pc_load) begin
                if (lq.size() == 0) begin
                    checkOutput("unexp_load", 16'(pc_load), 16'h0000);
                end else begin
                    logic [15:0] t;
                    t = lq.pop_front();
                    checkOutput("pc_value", pc_value, t);
                end
            end
        end
    end

    task automatic clearInputs();
        enable_cint       = 1'b0;
        P2_Reset_CINT     = 1'b0;
        P2_Set_CINT0_RST  = 1'b0;
        P2_Set_CINT0_CALL = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int   cycles;
        logic acc;
        acc = v.en && v.strobe && (v.rst || v.call);
        if (acc && v.rst) begin
            lq.push_back(16'h0000);
            model_sp = 8'hFF;
        end else if (acc && v.call) begin
            wq.push_back('{{8'h01, model_sp}, v.pc[15:8]});
            model_sp = model_sp - 8'd1;
            wq.push_back('{{8'h01, model_sp}, v.pc[7:0]});
            model_sp = model_sp - 8'd1;
            lq.push_back(16'h0008);
        end
        enable_cint       = v.en;
        P2_Reset_CINT     = v.strobe;
        P2_Set_CINT0_RST  = v.rst;
        P2_Set_CINT0_CALL = v.call;
        pc_in             = v.pc;
        mem_ready         = (v.wait_cycles == 0);
        @(posedge CLK); #1;
        clearInputs();
        pc_in = ~v.pc;
        if (!acc) begin
            checkOutput("idle_busy", 16'(busy), 16'h0000);
            @(posedge CLK); #1;
        end else begin
            cycles = 1;
            while (!pc_load && cycles < 50) begin
                mem_ready = (cycles > v.wait_cycles);
                if (!mem_ready && wq.size() > 0) begin
                    checkOutput("hold_we", 16'(mem_we), 16'h0001);
                    checkOutput("hold_addr", mem_addr, wq[0].addr);
                    checkOutput("hold_data", 16'(mem_wdata), 16'(wq[0].data));
                end
                if (v.busy_req) begin
                    enable_cint       = 1'b1;
                    P2_Reset_CINT     = 1'b1;
                    P2_Set_CINT0_RST  = 1'b1;
                    P2_Set_CINT0_CALL = 1'b1;
                end
                @(posedge CLK); #1;
                cycles++;
            end
            clearInputs();
            mem_ready = 1'b1;
            checkOutput("latency", 16'(cycles), 16'(v.exp_lat));
            @(posedge CLK); #1;
            checkOutput("done_busy", 16'(busy), 16'h0000);
            checkOutput("done_load", 16'(pc_load), 16'h0000);
        end
        checkOutput("sp", 16'(sp), 16'(v.exp_sp));
    endtask

    task automatic doReset();
        notRESET = 1'b0;
        clearInputs();
        mem_ready = 1'b1;
        wq.delete();
        lq.delete();
        model_sp = 8'hFF;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_busy", 16'(busy), 16'h0000);
        checkOutput("rst_sp", 16'(sp), 16'h00FF);
        checkOutput("rst_ovf", 16'(stack_ovf), 16'h0000);
        checkOutput("rst_we", 16'(mem_we), 16'h0000);
        checkOutput("rst_load", 16'(pc_load), 16'h0000);
        checkOutput("rst_pcval", pc_value, 16'h0000);
        checkOutput("rst_addr", mem_addr, 16'h0000);
        checkOutput("rst_wdata", 16'(mem_wdata), 16'h0000);
        notRESET = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        //              en  stb rst call pc        wait busyq lat sp
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 0, 1'b0, 3, 8'hFD};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD, 0, 1'b0, 3, 8'hFB};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 0, 1'b0, 1, 8'hFF};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 0, 1'b0, 0, 8'hFF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 0, 1'b0, 0, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 0, 1'b0, 0, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 4, 1'b0, 7, 8'hFD};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h4444, 0, 1'b0, 1, 8'hFF};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0F0F, 0, 1'b1, 3, 8'hFD};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 2, 1'b0, 5, 8'hFB};

        notRESET = 1'b0;
        pc_in    = 16'h0000;
        clearInputs();
        mem_ready = 1'b1;
        model_sp  = 8'hFF;
        doReset();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset asserted while the low byte is being pushed.
        doReset();
        wq.push_back('{16'h01FF, 8'h77});
        enable_cint       = 1'b1;
        P2_Reset_CINT     = 1'b1;
        P2_Set_CINT0_CALL = 1'b1;
        pc_in             = 16'h7788;
        @(posedge CLK); #1;
        clearInputs();
        @(posedge CLK); #1;
        checkOutput("midrst_lo_we", 16'(mem_we), 16'h0001);
        checkOutput("midrst_lo_addr", mem_addr, 16'h01FE);
        notRESET = 1'b0;
        #1;
        checkOutput("midrst_busy", 16'(busy), 16'h0000);
        checkOutput("midrst_sp", 16'(sp), 16'h00FF);
        checkOutput("midrst_we", 16'(mem_we), 16'h0000);
        @(posedge CLK); #1;
        notRESET = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checkOutput("midrst_noload", 16'(pc_load), 16'h0000);
        end
        model_sp = 8'hFF;

        // 128 CALLs from reset: the last low-byte push lands at 0x0100 and wraps sp.
        doReset();
        for (int i = 1; i <= 128; i++) begin
            if (i == 128) begin
                checkOutput("pre_wrap_sp", 16'(sp), 16'h0001);
                checkOutput("pre_wrap_ovf", 16'(stack_ovf), 16'h0000);
            end
            v = '{1'b1, 1'b1, 1'b0, 1'b1, 16'(i * 16'h0101), 0, 1'b0, 3, 8'(255 - 2 * i)};
            applyStimulus(v);
        end
        checkOutput("wrap_ovf", 16'(stack_ovf), 16'h0001);
        checkOutput("wrap_sp", 16'(sp), 16'h00FF);
        v = '{1'b1, 1'b1, 1'b1, 1'b0, 16'hCAFE, 0, 1'b0, 1, 8'hFF};
        applyStimulus(v);
        checkOutput("ovf_sticky", 16'(stack_ovf), 16'h0001);

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("wq_drained", 16'(wq.size()), 16'h0000);
        checkOutput("lq_drained", 16'(lq.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
